// File: rtl/jtag_tap_ctrl_mc_if.sv
// JTAG pin bundle between the board-level connector and the TAP controller.
// The slave side receives TCK/TMS/TDI/TRST and drives TDO.
interface jtag_interface;
   logic tck;
   logic tms;
   logic tdi;
   logic trst;
   logic tdo;

   modport master (output tck, output tms, output tdi, output trst, input tdo);
   modport slave  (input tck, input tms, input tdi, input trst, output tdo);
endinterface

// File: rtl/jtag_tap_ctrl_mc.sv
// IEEE 1149.1 TAP controller running in the clk domain with synchronised pins, BYPASS/IDCODE DRs and user DR strobes.
// Optional feature macro: JTAG_IDCODE_EN (IDCODE register present; otherwise the IDCODE opcode acts as BYPASS).
module jtag_tap_ctrl_mc #(
   parameter int unsigned                   INSTRUCTION_WIDTH = 4,
   parameter logic [INSTRUCTION_WIDTH-1:0]  IDCODE_INSTR      = {{(INSTRUCTION_WIDTH-1){1'b0}}, 1'b1},
   parameter logic [31:0]                   IDCODE_VALUE      = 32'h4e79_0001,
   parameter int unsigned                   SYNC_STAGES       = 2
) (
   input  logic                         clk,
   input  logic                         reset_n,
   jtag_interface.slave                 jtag,
   input  logic                         data_shift_val,
   output logic                         capture_dr,
   output logic                         shift_dr,
   output logic                         update_dr,
   output logic [INSTRUCTION_WIDTH-1:0] instruction,
   output logic                         update_ir,
   output logic [3:0]                   tap_state
);

   typedef enum logic [3:0] {
      TAP_RESET  = 4'd0,  TAP_IDLE   = 4'd1,  TAP_SEL_DR = 4'd2,  TAP_CAP_DR = 4'd3,
      TAP_SH_DR  = 4'd4,  TAP_EX1_DR = 4'd5,  TAP_PAU_DR = 4'd6,  TAP_EX2_DR = 4'd7,
      TAP_UPD_DR = 4'd8,  TAP_SEL_IR = 4'd9,  TAP_CAP_IR = 4'd10, TAP_SH_IR  = 4'd11,
      TAP_EX1_IR = 4'd12, TAP_PAU_IR = 4'd13, TAP_EX2_IR = 4'd14, TAP_UPD_IR = 4'd15
   } tap_state_e;

   localparam int unsigned W = INSTRUCTION_WIDTH;
   localparam logic [W-1:0] IR_CAPTURE = {{(W-1){1'b0}}, 1'b1};
   localparam logic [W-1:0] ALL_ONES   = {W{1'b1}};

   logic [SYNC_STAGES-1:0] tck_sync_q, tms_sync_q, tdi_sync_q, trst_sync_q;
   logic                   tck_last_q;
   logic                   tck_s, tms_s, tdi_s, trst_s, tck_rise_s, tck_fall_s;

   tap_state_e             state_q, state_d;
   logic [W-1:0]           instr_q, ir_shift_q;
   logic                   bypass_q, tdo_q;
   logic                   capture_dr_q, shift_dr_q, update_dr_q, update_ir_q;
   logic                   bypass_sel_s, user_sel_s, dr_tdo_s;

`ifdef JTAG_IDCODE_EN
   localparam logic [W-1:0] RESET_INSTR = IDCODE_INSTR;
   logic [31:0] idcode_q;
   logic        idcode_sel_s;
   assign idcode_sel_s = (instr_q == IDCODE_INSTR);
   assign bypass_sel_s = (instr_q == ALL_ONES);
   assign user_sel_s   = ~bypass_sel_s & ~idcode_sel_s;
`else
   localparam logic [W-1:0] RESET_INSTR = ALL_ONES;
   logic idcode_unused_s;
   assign idcode_unused_s = ^IDCODE_VALUE;
   assign bypass_sel_s    = (instr_q == ALL_ONES) | (instr_q == IDCODE_INSTR);
   assign user_sel_s      = ~bypass_sel_s;
`endif

   assign tck_s      = tck_sync_q[SYNC_STAGES-1];
   assign tms_s      = tms_sync_q[SYNC_STAGES-1];
   assign tdi_s      = tdi_sync_q[SYNC_STAGES-1];
   assign trst_s     = trst_sync_q[SYNC_STAGES-1];
   assign tck_rise_s = tck_s & ~tck_last_q;
   assign tck_fall_s = ~tck_s & tck_last_q;

   // Pin synchronisers and previous-TCK flop for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tck_sync_q  <= {SYNC_STAGES{1'b0}};
         tms_sync_q  <= {SYNC_STAGES{1'b0}};
         tdi_sync_q  <= {SYNC_STAGES{1'b0}};
         trst_sync_q <= {SYNC_STAGES{1'b0}};
         tck_last_q  <= 1'b0;
      end else begin
         tck_sync_q  <= {tck_sync_q[SYNC_STAGES-2:0], jtag.tck};
         tms_sync_q  <= {tms_sync_q[SYNC_STAGES-2:0], jtag.tms};
         tdi_sync_q  <= {tdi_sync_q[SYNC_STAGES-2:0], jtag.tdi};
         trst_sync_q <= {trst_sync_q[SYNC_STAGES-2:0], jtag.trst};
         tck_last_q  <= tck_s;
      end
   end

   // TAP next-state function on synchronised TMS.
   always_comb begin
      state_d = TAP_RESET;
      case (state_q)
         TAP_RESET:  state_d = tms_s ? TAP_RESET  : TAP_IDLE;
         TAP_IDLE:   state_d = tms_s ? TAP_SEL_DR : TAP_IDLE;
         TAP_SEL_DR: state_d = tms_s ? TAP_SEL_IR : TAP_CAP_DR;
         TAP_CAP_DR: state_d = tms_s ? TAP_EX1_DR : TAP_SH_DR;
         TAP_SH_DR:  state_d = tms_s ? TAP_EX1_DR : TAP_SH_DR;
         TAP_EX1_DR: state_d = tms_s ? TAP_UPD_DR : TAP_PAU_DR;
         TAP_PAU_DR: state_d = tms_s ? TAP_EX2_DR : TAP_PAU_DR;
         TAP_EX2_DR: state_d = tms_s ? TAP_UPD_DR : TAP_SH_DR;
         TAP_UPD_DR: state_d = tms_s ? TAP_SEL_DR : TAP_IDLE;
         TAP_SEL_IR: state_d = tms_s ? TAP_RESET  : TAP_CAP_IR;
         TAP_CAP_IR: state_d = tms_s ? TAP_EX1_IR : TAP_SH_IR;
         TAP_SH_IR:  state_d = tms_s ? TAP_EX1_IR : TAP_SH_IR;
         TAP_EX1_IR: state_d = tms_s ? TAP_UPD_IR : TAP_PAU_IR;
         TAP_PAU_IR: state_d = tms_s ? TAP_EX2_IR : TAP_PAU_IR;
         TAP_EX2_IR: state_d = tms_s ? TAP_UPD_IR : TAP_SH_IR;
         TAP_UPD_IR: state_d = tms_s ? TAP_SEL_DR : TAP_IDLE;
         default:    state_d = TAP_RESET;
      endcase
   end

   // Serial output source for SHIFT_DR, chosen by the active instruction.
   always_comb begin
      dr_tdo_s = data_shift_val;
      if (bypass_sel_s) begin
         dr_tdo_s = bypass_q;
`ifdef JTAG_IDCODE_EN
      end else if (idcode_sel_s) begin
         dr_tdo_s = idcode_q[0];
`endif
      end else begin
         dr_tdo_s = data_shift_val;
      end
   end

   // TAP state, IR/DR registers, TDO and one-clk strobes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= TAP_RESET;
         instr_q      <= RESET_INSTR;
         ir_shift_q   <= {W{1'b0}};
         bypass_q     <= 1'b0;
`ifdef JTAG_IDCODE_EN
         idcode_q     <= 32'h0000_0000;
`endif
         tdo_q        <= 1'b0;
         capture_dr_q <= 1'b0;
         shift_dr_q   <= 1'b0;
         update_dr_q  <= 1'b0;
         update_ir_q  <= 1'b0;
      end else begin
         capture_dr_q <= 1'b0;
         shift_dr_q   <= 1'b0;
         update_dr_q  <= 1'b0;
         update_ir_q  <= 1'b0;
         // TRST wins over a coincident TCK edge and aborts any scan without update.
         if (trst_s) begin
            state_q <= TAP_RESET;
            instr_q <= RESET_INSTR;
         end else if (tck_rise_s) begin
            state_q <= state_d;
            case (state_q)
               TAP_RESET:  instr_q <= RESET_INSTR;
               TAP_CAP_DR: begin
                  bypass_q <= 1'b0;
`ifdef JTAG_IDCODE_EN
                  if (idcode_sel_s) idcode_q <= IDCODE_VALUE;
`endif
               end
               TAP_SH_DR: begin
                  bypass_q   <= tdi_s;
`ifdef JTAG_IDCODE_EN
                  if (idcode_sel_s) idcode_q <= {tdi_s, idcode_q[31:1]};
`endif
                  shift_dr_q <= user_sel_s;
               end
               TAP_CAP_IR: ir_shift_q <= IR_CAPTURE;
               TAP_SH_IR:  ir_shift_q <= {tdi_s, ir_shift_q[W-1:1]};
               default: ;
            endcase
            capture_dr_q <= user_sel_s & (state_d == TAP_CAP_DR);
            update_dr_q  <= user_sel_s & (state_d == TAP_UPD_DR);
            if (state_d == TAP_UPD_IR) begin
               instr_q     <= ir_shift_q;
               update_ir_q <= 1'b1;
            end
         end else if (tck_fall_s) begin
            case (state_q)
               TAP_SH_IR: tdo_q <= ir_shift_q[0];
               TAP_SH_DR: tdo_q <= dr_tdo_s;
               default: ;
            endcase
         end else if (state_q == TAP_RESET) begin
            instr_q <= RESET_INSTR;
         end
      end
   end

   assign jtag.tdo    = tdo_q;
   assign capture_dr  = capture_dr_q;
   assign shift_dr    = shift_dr_q;
   assign update_dr   = update_dr_q;
   assign update_ir   = update_ir_q;
   assign instruction = instr_q;
   assign tap_state   = state_q;

endmodule

// File: tb/tb_jtag_tap_ctrl_mc.sv
// Directed bench for jtag_tap_ctrl_mc: TCK driven well below clk/4, expected scan words queued before each scan.
module tb_jtag_tap_ctrl_mc;
   localparam logic [31:0] IDV  = 32'h4e79_0001;
   localparam int          SYNC = 2;
`ifdef JTAG_IDCODE_EN
   localparam logic [3:0]  RST_INSTR = 4'h1;
`else
   localparam logic [3:0]  RST_INSTR = 4'hF;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       dsv = 1'b0;
   logic       capture_dr, shift_dr, update_dr, update_ir;
   logic [3:0] instruction, tap_state;

   jtag_interface jtag_if ();

   jtag_tap_ctrl_mc #(
      .INSTRUCTION_WIDTH(4), .IDCODE_INSTR(4'h1), .IDCODE_VALUE(IDV), .SYNC_STAGES(SYNC)
   ) dut (
      .clk(clk), .reset_n(reset_n), .jtag(jtag_if.slave), .data_shift_val(dsv),
      .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
      .instruction(instruction), .update_ir(update_ir), .tap_state(tap_state)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cap_cnt = 0, sh_cnt = 0, upd_cnt = 0, uir_cnt = 0;

   // Strobe pulse counters.
   always @(negedge clk) begin
      if (capture_dr) cap_cnt <= cap_cnt + 1;
      if (shift_dr)   sh_cnt  <= sh_cnt + 1;
      if (update_dr)  upd_cnt <= upd_cnt + 1;
      if (update_ir)  uir_cnt <= uir_cnt + 1;
   end

   string       sb_tag[$];
   logic [31:0] sb_exp[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [31:0] exp);
      sb_tag.push_back(tag);
      sb_exp.push_back(exp);
   endtask

   task automatic sb_pop_check(input logic [31:0] obs);
      string       t;
      logic [31:0] e;
      if (sb_exp.size() == 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL scoreboard: observed 0x%0h expected a queued entry", obs);
      end else begin
         t = sb_tag.pop_front();
         e = sb_exp.pop_front();
         check(t, obs, e);
      end
   endtask

   task automatic tck_pulse(input logic tms_v, input logic tdi_v, input logic dsv_v);
      jtag_if.tms = tms_v;
      jtag_if.tdi = tdi_v;
      dsv         = dsv_v;
      repeat (4) @(negedge clk);
      jtag_if.tck = 1'b1;
      repeat (4) @(negedge clk);
      jtag_if.tck = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   // IDLE -> DR scan of n bits -> IDLE; returns TDO bits LSB first.
   task automatic dr_scan(input int n, input logic [31:0] tdi_bits, input logic [31:0] dsv_bits,
                          output logic [31:0] tdo_bits);
      tdo_bits = 32'h0;
      tck_pulse(1'b1, 1'b0, 1'b0);
      tck_pulse(1'b0, 1'b0, 1'b0);
      tck_pulse(1'b0, 1'b0, dsv_bits[0]);
      tdo_bits[0] = jtag_if.tdo;
      for (int i = 0; i < n; i++) begin
         tck_pulse((i == n - 1), tdi_bits[i], (i < n - 1) ? dsv_bits[(i + 1) % 32] : 1'b0);
         if (i < n - 1) tdo_bits[i + 1] = jtag_if.tdo;
      end
      tck_pulse(1'b1, 1'b0, 1'b0);
      tck_pulse(1'b0, 1'b0, 1'b0);
   endtask

   // IDLE -> IR scan of n bits, stopping in EX1_IR.
   task automatic ir_to_exit(input int n, input logic [31:0] tdi_bits, output logic [31:0] tdo_bits);
      tdo_bits = 32'h0;
      tck_pulse(1'b1, 1'b0, 1'b0);
      tck_pulse(1'b1, 1'b0, 1'b0);
      tck_pulse(1'b0, 1'b0, 1'b0);
      tck_pulse(1'b0, 1'b0, 1'b0);
      tdo_bits[0] = jtag_if.tdo;
      for (int i = 0; i < n; i++) begin
         tck_pulse((i == n - 1), tdi_bits[i], 1'b0);
         if (i < n - 1) tdo_bits[i + 1] = jtag_if.tdo;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] word, pat, dpat;
      int          c0, s0, u0, ir0;

      jtag_if.tck  = 1'b0;
      jtag_if.tms  = 1'b1;
      jtag_if.tdi  = 1'b0;
      jtag_if.trst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_state", 32'(tap_state), 32'd0);
      check("reset_instr", 32'(instruction), 32'(RST_INSTR));
      check("reset_tdo", 32'(jtag_if.tdo), 32'd0);
      check("reset_strobes", 32'({capture_dr, shift_dr, update_dr, update_ir}), 32'd0);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);

      tck_pulse(1'b0, 1'b0, 1'b0);
      check("to_idle", 32'(tap_state), 32'd1);

      // Reset-instruction DR read: IDCODE when present, otherwise BYPASS.
      c0 = cap_cnt; s0 = sh_cnt; u0 = upd_cnt;
`ifdef JTAG_IDCODE_EN
      sb_push("idcode_read", IDV);
      dr_scan(32, 32'h0000_0000, 32'h0000_0000, word);
`else
      pat = 32'hC3A5_0F96;
      sb_push("reset_bypass_read", pat << 1);
      dr_scan(32, pat, 32'h0000_0000, word);
`endif
      sb_pop_check(word);
      check("builtin_dr_no_strobes", 32'(cap_cnt - c0 + sh_cnt - s0 + upd_cnt - u0), 32'd0);
      check("back_to_idle", 32'(tap_state), 32'd1);

      // IR scan of 4'h2.
      ir0 = uir_cnt;
      sb_push("ir_capture_tdo", 32'h0000_0001);
      ir_to_exit(4, 32'h0000_0002, word);
      sb_pop_check(word);
      check("instr_held_before_update", 32'(instruction), 32'(RST_INSTR));
      check("no_update_ir_yet", 32'(uir_cnt - ir0), 32'd0);
      tck_pulse(1'b1, 1'b0, 1'b0);
      check("state_upd_ir", 32'(tap_state), 32'd15);
      check("update_ir_once", 32'(uir_cnt - ir0), 32'd1);
      check("instr_after_update", 32'(instruction), 32'h2);
      tck_pulse(1'b0, 1'b0, 1'b0);

      // User DR, 8 bits.
      dpat = 32'($urandom_range(0, 255));
      pat  = $urandom;
      c0 = cap_cnt; s0 = sh_cnt; u0 = upd_cnt;
      sb_push("user_dr_tdo", dpat);
      dr_scan(8, pat, dpat, word);
      sb_pop_check(word);
      check("user_capture_cnt", 32'(cap_cnt - c0), 32'd1);
      check("user_shift_cnt", 32'(sh_cnt - s0), 32'd8);
      check("user_update_cnt", 32'(upd_cnt - u0), 32'd1);

      // BYPASS: 0 then 0xA5 delayed one TCK.
      ir_to_exit(4, 32'h0000_000F, word);
      tck_pulse(1'b1, 1'b0, 1'b0);
      tck_pulse(1'b0, 1'b0, 1'b0);
      check("instr_bypass", 32'(instruction), 32'hF);
      c0 = cap_cnt; s0 = sh_cnt; u0 = upd_cnt;
      sb_push("bypass_tdo", 32'h0000_014A);
      dr_scan(9, 32'h0000_00A5, 32'h0000_01FF, word);
      sb_pop_check(word);
      check("bypass_no_strobes", 32'(cap_cnt - c0 + sh_cnt - s0 + upd_cnt - u0), 32'd0);

      // Five TMS ones from SH_DR reach RESET.
      tck_pulse(1'b1, 1'b0, 1'b0);
      tck_pulse(1'b0, 1'b0, 1'b0);
      tck_pulse(1'b0, 1'b0, 1'b0);
      check("in_sh_dr", 32'(tap_state), 32'd4);
      for (int i = 0; i < 5; i++) tck_pulse(1'b1, 1'b0, 1'b0);
      check("tms_five_reset", 32'(tap_state), 32'd0);
      check("tms_five_instr", 32'(instruction), 32'(RST_INSTR));
      tck_pulse(1'b0, 1'b0, 1'b0);

      // TRST mid SH_IR aborts without update_ir.
      ir_to_exit(4, 32'h0000_0002, word);
      tck_pulse(1'b1, 1'b0, 1'b0);
      tck_pulse(1'b0, 1'b0, 1'b0);
      check("instr_reload", 32'(instruction), 32'h2);
      ir0 = uir_cnt;
      tck_pulse(1'b1, 1'b0, 1'b0);
      tck_pulse(1'b1, 1'b0, 1'b0);
      tck_pulse(1'b0, 1'b0, 1'b0);
      tck_pulse(1'b0, 1'b0, 1'b0);
      tck_pulse(1'b0, 1'b1, 1'b0);
      tck_pulse(1'b0, 1'b1, 1'b0);
      check("in_sh_ir", 32'(tap_state), 32'd11);
      jtag_if.trst = 1'b1;
      repeat (SYNC) @(negedge clk);
      check("trst_not_before_latency", 32'(tap_state), 32'd11);
      @(negedge clk);
      check("trst_state", 32'(tap_state), 32'd0);
      jtag_if.trst = 1'b0;
      repeat (4) @(negedge clk);
      check("trst_instr", 32'(instruction), 32'(RST_INSTR));
      check("trst_no_update_ir", 32'(uir_cnt - ir0), 32'd0);

      // Asynchronous reset_n mid SH_DR.
      tck_pulse(1'b0, 1'b0, 1'b0);
      tck_pulse(1'b1, 1'b0, 1'b0);
      tck_pulse(1'b0, 1'b0, 1'b0);
      tck_pulse(1'b0, 1'b0, 1'b0);
      check("in_sh_dr_again", 32'(tap_state), 32'd4);
      reset_n = 1'b0;
      #1;
      check("async_reset_state", 32'(tap_state), 32'd0);
      check("async_reset_tdo", 32'(jtag_if.tdo), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
